weight_bank_pp: RTL and testbench

Double-buffered (ping-pong) weight bank holding (Tn/Y)*(Tm/X)*k*k coefficients per buffer, with a runtime-selectable kernel size k ≤ K. The weight loader fills one buffer while the convolution core reads the other, so weight loading overlaps compute. Per-buffer valid flags and a release handshake control ownership. Sits between the weight DMA/loader and one conv PE column group; replaces the single-buffer weight bank.

---
 rtl/weight_bank_pkg.sv | 27 ++
 rtl/dp_ram_bhm.sv | 20 ++
 rtl/weight_bank_pp.sv | 93 +++++++++
 tb/tb_weight_bank_pp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/weight_bank_pkg.sv
// Shared constants and helpers for the ping-pong weight bank.
// Capacity is derived from the tile geometry and the runtime kernel size.
package weight_bank_pkg;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TN = 16;
    localparam int TM = 16;
    localparam int K  = 3;
    localparam int X  = 4;
    localparam int Y  = 4;
    localparam int KW = 4;

    localparam int BANK_CAP_MAX = (TN / Y) * (TM / X) * K * K;
    localparam int CAP_W        = AW + 1;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Kernel sizes outside 1..K fall back to the maximum kernel.
    function automatic logic [CAP_W-1:0] cap_of(input logic [KW-1:0] k);
        int unsigned ke;
        ke = (k >= KW'(1) && k <= KW'(K)) ? 32'(k) : 32'(K);
        return CAP_W'((TN / Y) * (TM / X) * ke * ke);
    endfunction
endpackage

// File: rtl/dp_ram_bhm.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module dp_ram_bhm #(
    parameter int AW  = 9,
    parameter int DW  = 32,
    parameter int NUM = 512
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [NUM];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/weight_bank_pp.sv
// Double-buffered weight bank: the loader fills one half of the RAM while the
// conv core reads the other; valid flags and a release pulse pass ownership.
module weight_bank_pp
    import weight_bank_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [KW-1:0] cfg_k,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_ena,
    output logic          wr_ready,
    input  logic          conv_tile_clean,
    output logic [AW-1:0] wr_count,
    output logic          fill_done,
    output logic          wr_overflow,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_release
);
    logic             wr_sel, rd_sel, fill_buf;
    logic [1:0]       bank_valid, bank_next;
    logic [CAP_W-1:0] cap_reg;
    logic             we_q;
    logic [AW:0]      wa_q;
    logic [DW-1:0]    wd_q;
    logic             accept, last, release_ok;

    assign wr_ready   = ~bank_valid[wr_sel];
    assign rd_valid   = bank_valid[rd_sel];
    assign accept     = wr_ena & wr_ready & ~conv_tile_clean;
    assign last       = ({1'b0, wr_count} == cap_reg - CAP_W'(1));
    assign release_ok = rd_release & rd_valid;

    // Release and fill completion target different halves, so both apply.
    always_comb begin
        bank_next = bank_valid;
        if (release_ok) bank_next[rd_sel]   = BUF_EMPTY;
        if (fill_done)  bank_next[fill_buf] = BUF_FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            fill_buf    <= 1'b0;
            bank_valid  <= 2'b00;
            wr_count    <= '0;
            cap_reg     <= cap_of(KW'(K));
            fill_done   <= 1'b0;
            wr_overflow <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            if (wr_count == '0) cap_reg <= cap_of(cfg_k);
            if (wr_ena & ~wr_ready) wr_overflow <= 1'b1;
            we_q       <= accept;
            fill_done  <= accept & last;
            fill_buf   <= wr_sel;
            bank_valid <= bank_next;
            if (release_ok) rd_sel <= ~rd_sel;
            if (conv_tile_clean) begin
                wr_count <= '0;
            end else if (accept) begin
                if (last) begin
                    wr_count <= '0;
                    wr_sel   <= ~wr_sel;
                end else begin
                    wr_count <= wr_count + AW'(1);
                end
            end
        end
    end

    // Write data is staged one cycle; the valid flag trails it so the last
    // word is in the RAM before rd_valid rises.
    always_ff @(posedge clk) begin
        wa_q <= {wr_sel, wr_count};
        wd_q <= wr_data;
    end

    dp_ram_bhm #(
        .AW  (AW + 1),
        .DW  (DW),
        .NUM (2 * (2 ** AW))
    ) u_ram (
        .clk   (clk),
        .we    (we_q),
        .waddr (wa_q),
        .wdata (wd_q),
        .raddr ({rd_sel, rd_addr}),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_weight_bank_pp.sv
// Scoreboard bench for weight_bank_pp against a queue-of-completed-fills model.
module tb_weight_bank_pp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cfg_k = 4'd3;
    logic [31:0] wr_data = '0;
    logic        wr_ena = 1'b0;
    logic        wr_ready;
    logic        conv_tile_clean = 1'b0;
    logic [7:0]  wr_count;
    logic        fill_done;
    logic        wr_overflow;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_release = 1'b0;

    weight_bank_pp dut (
        .clk(clk), .rst(rst), .cfg_k(cfg_k), .wr_data(wr_data), .wr_ena(wr_ena),
        .wr_ready(wr_ready), .conv_tile_clean(conv_tile_clean), .wr_count(wr_count),
        .fill_done(fill_done), .wr_overflow(wr_overflow), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_release(rd_release)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: completed fills are queued in fill order with the cycle
    // from which they become readable; reads hit the oldest one.
    logic [31:0] fdata [16][256];
    int          fcap [16];
    int          full_q[$];
    int          ready_q[$];
    logic [31:0] exp_q[$];
    int cyc = 0, cnt = 0, cap = 144, slot = 0;
    bit ovf = 0, done_prev = 0;
    logic rd_req = 1'b0, rd_pend = 1'b0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL rd_data: unexpected read result %0h", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    function automatic int cap_for(input logic [3:0] k);
        int ke;
        ke = int'(k);
        if (ke < 1 || ke > 3) ke = 3;
        return (16 / 4) * (16 / 4) * ke * ke;
    endfunction

    // One clock: check state, drive inputs, advance model. a<0 = random read address.
    task automatic step(input bit we, input logic [31:0] d, input bit re, input int a,
                        input bit clean, input bit rel);
        bit rdy, vld;
        bit done_now;
        int ra;
        rdy = (full_q.size() < 2);
        vld = (full_q.size() > 0) && (cyc >= ready_q[0]);
        check("wr_ready", wr_ready, rdy);
        check("rd_valid", rd_valid, vld);
        check("wr_count", wr_count, cnt);
        check("fill_done", fill_done, done_prev);
        check("wr_overflow", wr_overflow, ovf);
        wr_ena = we; wr_data = d; conv_tile_clean = clean; rd_release = rel;
        rd_req = 1'b0;
        if (re && vld) begin
            ra = (a < 0) ? $urandom_range(0, fcap[full_q[0]] - 1) : a;
            rd_addr = 8'(ra);
            exp_q.push_back(fdata[full_q[0]][ra]);
            rd_req = 1'b1;
        end
        if (we && !rdy) ovf = 1;
        done_now = 0;
        if (clean) begin
            cnt = 0;
        end else if (we && rdy) begin
            if (cnt == 0) cap = cap_for(cfg_k);
            fdata[slot][cnt] = d;
            cnt++;
            if (cnt == cap) begin
                fcap[slot] = cap;
                full_q.push_back(slot);
                ready_q.push_back(cyc + 2);
                slot = (slot + 1) % 16;
                cnt = 0;
                done_now = 1;
            end
        end
        if (rel && vld) begin
            void'(full_q.pop_front());
            void'(ready_q.pop_front());
        end
        @(posedge clk); #1;
        cyc++;
        done_prev = done_now;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic fill(input int n, input int base, input bit rnd, input bit rd);
        for (int i = 0; i < n; i++)
            step(1, rnd ? 32'($urandom) : 32'(base + i), rd, -1, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_ena = 0; conv_tile_clean = 0; rd_release = 0; rd_req = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        full_q.delete(); ready_q.delete();
        cnt = 0; ovf = 0; done_prev = 0;
    endtask

    initial begin
        do_reset();
        // Reset state, then a k=3 fill with data=i and a read of address 5
        cfg_k = 4'd3;
        fill(144, 0, 0, 0);
        idle(2);
        step(0, '0, 1, 5, 0, 0);
        // Second fill while reading, then an overflowing third write and a release
        fill(144, 1000, 0, 1);
        idle(2);
        step(1, 32'hdead, 0, 0, 0, 0);
        step(0, '0, 1, 5, 0, 1);
        step(0, '0, 1, 5, 0, 0);
        // k=1 fill, then k=0 clamps to the maximum kernel
        cfg_k = 4'd1;
        fill(16, 0, 1, 1);
        idle(2);
        step(0, '0, 1, -1, 0, 1);
        cfg_k = 4'd0;
        fill(144, 0, 1, 1);
        idle(2);
        // Abort a partial fill with a colliding write, then refill the same half
        step(0, '0, 1, -1, 0, 1);
        cfg_k = 4'd3;
        fill(10, 0, 1, 0);
        step(1, 32'hbad, 0, 0, 1, 0);
        fill(144, 500, 0, 0);
        idle(2);
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 1, 0, 0, 0);
        // Release with nothing valid is ignored; reset mid-fill clears everything
        step(0, '0, 0, 0, 0, 1);
        idle(2);
        step(0, '0, 0, 0, 0, 1);
        fill(50, 0, 1, 0);
        do_reset();
        fill(144, 0, 0, 0);
        idle(2);
        step(0, '0, 1, 5, 0, 0);
        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) cfg_k = 4'($urandom_range(0, 5));
            step($urandom_range(0, 3) != 0, 32'($urandom), $urandom_range(0, 1),
                 -1, $urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0);
        end
        idle(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
